banked_mem_responder: RTL and testbench

- Memory-side responder for the cache controller's memory port. Services single-word requests (rd/wr, addr, data_in) from the cache FSM.
- Returns data_out, per-bank busy[3:0], stall and err.
- Four word-interleaved banks with fixed read latency and bank occupancy, so the controller can pipeline line fills and evictions across banks.
- Sits between the cache FSM and the backing storage array inside the memory system.

---
 rtl/banked_mem_responder.sv | 123 ++++++++++++
 tb/tb_banked_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_responder.sv
// -----------------------------------------------------------------------------
// banked_mem_responder
//
// Memory-side responder for the cache controller's memory port. It services
// single-word read/write requests against a word-interleaved array of four
// banks. Each bank stays occupied for a fixed number of cycles after it
// accepts a request. Reads return two cycles after acceptance. This lets the
// cache FSM overlap line fills and evictions across the banks.
//
// Parameters:
//   MEM_AW      word-address bits of the storage array (uses addr[MEM_AW:1];
//               upper address bits alias when MEM_AW < 15)
//   BUSY_CYCLES cycles a bank is occupied, counting the accept cycle (3..7)
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   asynchronous active-low reset
//   addr      in   byte address; bank = addr[2:1], word = addr[MEM_AW:1]
//   data_in   in   write data
//   wr        in   write request
//   rd        in   read request
//   data_out  out  read data during the read's return cycle, otherwise 0
//   busy      out  per-bank occupancy, derived from registered counters
//   stall     out  request targets a busy bank and is not accepted
//   err       out  unaligned address or simultaneous rd+wr
// -----------------------------------------------------------------------------
module banked_mem_responder #(
  parameter int MEM_AW      = 15,
  parameter int BUSY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic [3:0]  busy,
  output logic        stall,
  output logic        err
);

  localparam int         DATA_W    = 16;
  localparam logic [2:0] BUSY_LOAD = 3'(BUSY_CYCLES - 1);

  logic              req;
  logic              acc;
  logic [1:0]        bank;
  logic [MEM_AW-1:0] waddr;
  logic              unused_addr_bits;

  logic [2:0]        cnt_q [4];
  logic [2:0]        cnt_d [4];

  logic              vld_p1_q;
  logic [MEM_AW-1:0] raddr_p1_q;
  logic              vld_p2_q;
  logic [DATA_W-1:0] rdata_p2_q;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  assign req   = rd | wr;
  assign bank  = addr[2:1];
  assign waddr = addr[MEM_AW:1];

  // Address bits above MEM_AW deliberately alias and are ignored.
  assign unused_addr_bits = ^addr;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      busy[b] = (cnt_q[b] != 3'd0);
    end
  end

  // Error takes priority over stall. Gating with rst means nothing is
  // accepted and nothing is written while reset is held.
  assign err   = req & (addr[0] | (rd & wr));
  assign stall = rst & req & ~err & busy[bank];
  assign acc   = rst & req & ~err & ~busy[bank];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      cnt_d[b] = (cnt_q[b] != 3'd0) ? cnt_q[b] - 3'd1 : 3'd0;
      if (acc && (bank == 2'(b))) begin
        cnt_d[b] = BUSY_LOAD;
      end
    end
  end

  // Control state: bank counters and read-pipeline valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= 3'd0;
      end
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      vld_p1_q <= acc & rd;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Data path: storage, stage-1 address, stage-2 read data (no reset).
  always_ff @(posedge clk) begin
    if (acc && wr) begin
      mem[waddr] <= data_in;
    end
    // ---- stage 1: capture word address at the accept edge ----
    if (acc && rd) begin
      raddr_p1_q <= waddr;
    end
    // ---- stage 2: sample the array one edge later ----
    // A write accepted in the same cycle does not affect this sample.
    rdata_p2_q <= mem[raddr_p1_q];
  end

  assign data_out = vld_p2_q ? rdata_p2_q : '0;

endmodule

// File: tb/tb_banked_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_banked_mem_responder
//
// Self-checking bench for banked_mem_responder. A per-cycle vector table covers
// writes, reads, stalls, errors and the occupancy pattern. Hand-written
// sequences cover reset behaviour, same-cycle bank conflict versus
// interleave, and address aliasing on a second instance with MEM_AW=8.
// -----------------------------------------------------------------------------
module tb_banked_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out, data_out2;
  logic [3:0]  busy, busy2;
  logic        stall, stall2;
  logic        err, err2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        stall;
    logic        err;
    logic [3:0]  busy;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  banked_mem_responder #(.MEM_AW(15), .BUSY_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .busy(busy), .stall(stall), .err(err)
  );

  banked_mem_responder #(.MEM_AW(8), .BUSY_CYCLES(4)) dut_alias (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out2), .busy(busy2), .stall(stall2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic s, input logic e, input logic [3:0] b, input logic [15:0] o);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.din = d;
    v.stall = s; v.err = e; v.busy = b; v.dout = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; data_in = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset state, with requests presented while reset is held.
    #2;
    chk("reset_busy", 16'(busy), 16'h0000);
    chk("reset_dout", data_out, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("reset_stall", 16'(stall), 16'h0000);
    chk("reset_err_clean", 16'(err), 16'h0000);
    drive(1'b1, 1'b0, 16'h0003, 16'h0000);
    #1;
    chk("reset_err_odd", 16'(err), 16'h0001);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Each vector gives the inputs for one cycle and the outputs expected
    // in that same cycle: rd wr addr din | stall err busy dout.
    // Write then read on bank 0 (0x0008 -> addr[2:1]=00).
    add(0,1,16'h0008,16'hBEEF, 0,0,4'b0000,16'h0000);
    add(1,0,16'h0008,16'h0000, 1,0,4'b0001,16'h0000);
    add(1,0,16'h0008,16'h0000, 1,0,4'b0001,16'h0000);
    add(1,0,16'h0008,16'h0000, 1,0,4'b0001,16'h0000);
    add(1,0,16'h0008,16'h0000, 0,0,4'b0000,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0001,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0001,16'hBEEF);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0001,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0000,16'h0000);
    // Four-bank burst: writes then reads in consecutive cycles.
    add(0,1,16'h0100,16'h1111, 0,0,4'b0000,16'h0000);
    add(0,1,16'h0102,16'h2222, 0,0,4'b0001,16'h0000);
    add(0,1,16'h0104,16'h3333, 0,0,4'b0011,16'h0000);
    add(0,1,16'h0106,16'h4444, 0,0,4'b0111,16'h0000);
    add(1,0,16'h0100,16'h0000, 0,0,4'b1110,16'h0000);
    add(1,0,16'h0102,16'h0000, 0,0,4'b1101,16'h0000);
    add(1,0,16'h0104,16'h0000, 0,0,4'b1011,16'h1111);
    add(1,0,16'h0106,16'h0000, 0,0,4'b0111,16'h2222);
    add(0,0,16'h0000,16'h0000, 0,0,4'b1110,16'h3333);
    add(0,0,16'h0000,16'h0000, 0,0,4'b1100,16'h4444);
    add(0,0,16'h0000,16'h0000, 0,0,4'b1000,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0000,16'h0000);
    // Preload words used by the interleave sequence below.
    add(0,1,16'h0000,16'hCAFE, 0,0,4'b0000,16'h0000);
    add(0,1,16'h0002,16'hF00D, 0,0,4'b0001,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0011,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0011,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0010,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0000,16'h0000);
    // Errors: unaligned read, then rd+wr to a busy bank (err wins, no write).
    add(1,0,16'h0021,16'h0000, 0,1,4'b0000,16'h0000);
    add(0,1,16'h0020,16'h5A5A, 0,0,4'b0000,16'h0000);
    add(1,1,16'h0020,16'hDEAD, 0,1,4'b0001,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0001,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0001,16'h0000);
    add(1,0,16'h0020,16'h0000, 0,0,4'b0000,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0001,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0001,16'h5A5A);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0001,16'h0000);
    add(0,0,16'h0000,16'h0000, 0,0,4'b0000,16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      #3;
      chk($sformatf("v%0d_stall", i), 16'(stall), 16'(vecs[i].stall));
      chk($sformatf("v%0d_err", i),   16'(err),   16'(vecs[i].err));
      chk($sformatf("v%0d_busy", i),  16'(busy),  16'(vecs[i].busy));
      chk($sformatf("v%0d_dout", i),  data_out,   vecs[i].dout);
      tick;
    end

    // Bank conflict versus interleave within one cycle.
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("ilv_first_stall", 16'(stall), 16'h0000);
    tick;
    drive(1'b1, 1'b0, 16'h0008, 16'h0000);
    #1;
    chk("ilv_same_bank_stall", 16'(stall), 16'h0001);
    chk("ilv_busy", 16'(busy), 16'h0001);
    drive(1'b1, 1'b0, 16'h0002, 16'h0000);
    #1;
    chk("ilv_other_bank_stall", 16'(stall), 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("ilv_dout_t2", data_out, 16'hCAFE);
    tick;
    chk("ilv_dout_t3", data_out, 16'hF00D);
    tick;
    chk("ilv_dout_t4", data_out, 16'h0000);
    tick;

    // Storage survives reset; requests held in reset are not accepted;
    // the first edge after release accepts.
    drive(1'b0, 1'b1, 16'h0040, 16'h1111);
    tick;
    drive(1'b0, 1'b1, 16'h0042, 16'h4444);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick;
    tick;
    tick;
    drive(1'b0, 1'b1, 16'h0042, 16'h2222);
    rst = 1'b0;
    #1;
    chk("rr_busy_in_reset", 16'(busy), 16'h0000);
    chk("rr_stall_in_reset", 16'(stall), 16'h0000);
    tick;
    tick;
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    #1;
    chk("rr_release_stall", 16'(stall), 16'h0000);
    tick;
    chk("rr_first_accept_busy", 16'(busy), 16'h0001);
    drive(1'b1, 1'b0, 16'h0042, 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rr_dout_0040", data_out, 16'h1111);
    tick;
    chk("rr_dout_0042", data_out, 16'h4444);
    tick;
    tick;
    tick;
    tick;

    // Reset during an in-flight read discards it.
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    tick;
    chk("mr_busy_before", 16'(busy), 16'h0001);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_busy_async", 16'(busy), 16'h0000);
    chk("mr_dout_t1", data_out, 16'h0000);
    tick;
    chk("mr_dout_t2_in_reset", data_out, 16'h0000);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_dout_t2", data_out, 16'h0000);
    tick;
    chk("mr_dout_t3", data_out, 16'h0000);
    tick;
    chk("mr_dout_t4", data_out, 16'h0000);
    chk("mr_busy_t4", 16'(busy), 16'h0000);
    tick;

    // Aliasing on the MEM_AW=8 instance: 0x0202 maps to the same word as
    // 0x0002 (word 0x01) and to the same bank (1).
    drive(1'b0, 1'b1, 16'h0002, 16'hA5A5);
    tick;
    drive(1'b1, 1'b0, 16'h0202, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("al_stall_t%0d", k), 16'(stall2), 16'h0001);
      tick;
    end
    #1;
    chk("al_stall_t4", 16'(stall2), 16'h0000);
    chk("al_err", 16'(err2), 16'h0000);
    chk("al_busy_t4", 16'(busy2), 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("al_dout_t5", data_out2, 16'h0000);
    tick;
    chk("al_dout_t6", data_out2, 16'hA5A5);
    tick;
    chk("al_dout_t7", data_out2, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
